// File: rtl/camera_pkg.sv
// +----------------------------------------------------------------------------+
// | camera_pkg: shared types and register map for the camera param sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_EYE_X    = 3'd0;
  localparam logic [2:0] ADDR_EYE_Y    = 3'd1;
  localparam logic [2:0] ADDR_EYE_Z    = 3'd2;
  localparam logic [2:0] ADDR_LOOKAT_X = 3'd3;
  localparam logic [2:0] ADDR_LOOKAT_Y = 3'd4;
  localparam logic [2:0] ADDR_LOOKAT_Z = 3'd5;
  localparam logic [2:0] ADDR_CTRL     = 3'd6;
  localparam logic [2:0] ADDR_STATUS   = 3'd7;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_FORCE  = 1;

endpackage

`default_nettype wire

// File: rtl/camera_shadow_regfile.sv
// +----------------------------------------------------------------------------+
// | camera_shadow_regfile: six HPS-visible shadow words, write decode, read mux.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module camera_shadow_regfile
  import camera_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [DATA_W-1:0]      writedata,
  input  logic [DATA_W-1:0]      status,
  output logic [DATA_W-1:0]      readdata,
  output logic [5:0][DATA_W-1:0] shadow
);

  logic                   w_wr;
  logic [5:0][DATA_W-1:0] r_shadow;

  assign w_wr   = chipselect && !write_n;
  assign shadow = r_shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_EYE_X:    r_shadow[0] <= writedata;
        ADDR_EYE_Y:    r_shadow[1] <= writedata;
        ADDR_EYE_Z:    r_shadow[2] <= writedata;
        ADDR_LOOKAT_X: r_shadow[3] <= writedata;
        ADDR_LOOKAT_Y: r_shadow[4] <= writedata;
        ADDR_LOOKAT_Z: r_shadow[5] <= writedata;
        default: ;
      endcase
    end
  end

  // CTRL is write-only and reads back as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_EYE_X:    readdata = r_shadow[0];
      ADDR_EYE_Y:    readdata = r_shadow[1];
      ADDR_EYE_Z:    readdata = r_shadow[2];
      ADDR_LOOKAT_X: readdata = r_shadow[3];
      ADDR_LOOKAT_Y: readdata = r_shadow[4];
      ADDR_LOOKAT_Z: readdata = r_shadow[5];
      ADDR_STATUS:   readdata = status;
      default:       readdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/camera_param_sequencer.sv
// +----------------------------------------------------------------------------+
// | camera_param_sequencer: frame-synchronous atomic commit of camera vectors. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module camera_param_sequencer
  import camera_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] eye_x,
  output logic [DATA_W-1:0] eye_y,
  output logic [DATA_W-1:0] eye_z,
  output logic [DATA_W-1:0] lookat_x,
  output logic [DATA_W-1:0] lookat_y,
  output logic [DATA_W-1:0] lookat_z,
  output logic              params_updated,
  output logic              commit_pending
);

  state_t                 r_state;
  logic [5:0][DATA_W-1:0] r_active;
  logic [5:0][DATA_W-1:0] w_shadow;
  logic [CNT_W-1:0]       r_count;
  logic                   r_params_updated;
  logic                   w_ctrl_wr;
  logic                   w_commit;
  logic                   w_force;
  logic [DATA_W-1:0]      w_status;

  assign w_ctrl_wr = chipselect && !write_n && (address == ADDR_CTRL);
  assign w_commit  = w_ctrl_wr && writedata[CTRL_COMMIT];
  assign w_force   = w_ctrl_wr && writedata[CTRL_FORCE];

  assign w_status = {r_count, {(DATA_W-CNT_W-2){1'b0}},
                     (r_state == APPLY), (r_state == PENDING)};

  camera_shadow_regfile #(
    .DATA_W (DATA_W)
  ) u_shadow (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .status     (w_status),
    .readdata   (readdata),
    .shadow     (w_shadow)
  );

  // Shadow is sampled pre-edge, so a shadow write on the APPLY edge is not copied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_active         <= '0;
      r_count          <= '0;
      r_params_updated <= 1'b0;
    end else begin
      r_params_updated <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_force)       r_state <= APPLY;
          else if (w_commit) r_state <= PENDING;
        end
        PENDING: begin
          if (frame_sync || w_force) r_state <= APPLY;
        end
        APPLY: begin
          r_active         <= w_shadow;
          r_params_updated <= 1'b1;
          r_count          <= r_count + 1'b1;
          r_state          <= (w_commit || w_force) ? PENDING : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign eye_x          = r_active[0];
  assign eye_y          = r_active[1];
  assign eye_z          = r_active[2];
  assign lookat_x       = r_active[3];
  assign lookat_y       = r_active[4];
  assign lookat_z       = r_active[5];
  assign params_updated = r_params_updated;
  assign commit_pending = (r_state == PENDING);

endmodule

`default_nettype wire

// File: doc/camera_param_sequencer.md
Name: camera_param_sequencer

Overview:
- Avalon-MM slave that holds shadow copies of the camera eye and lookat vectors written by the HPS.
- Copies all six words into the active registers atomically at a frame boundary, so the raymarching core never renders with a half-updated camera.
- Sits between the HPS lightweight bridge and the raymarch pipeline's camera inputs.
- Replaces the individual per-component output ports for camera state.

Parameters:
- DATA_W, 32, width of each camera component word and of the Avalon data bus.
- CNT_W, 16, width of the commit counter reported in STATUS[31:16].

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  DATA_W  Avalon write data.
- readdata  out  DATA_W  Avalon read data, combinational from address.
- frame_sync  in  1  one-cycle pulse at the start of each frame (vertical blank), from the video timing block.
- eye_x, eye_y, eye_z  out  DATA_W each  active eye position, fixed-point as produced by HPS software.
- lookat_x, lookat_y, lookat_z  out  DATA_W each  active lookat point.
- params_updated  out  1  one-cycle pulse after the active registers change.
- commit_pending  out  1  high while a commit is waiting for frame_sync.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all shadow and active registers 0; state IDLE; commit counter 0; params_updated 0; commit_pending 0.
- Address map:
  - 0–2: shadow eye x/y/z (R/W).
  - 3–5: shadow lookat x/y/z (R/W).
  - 6: CTRL (W). bit0 = commit on next frame_sync; bit1 = force commit now. Reads return 0.
  - 7: STATUS (R). bit0 = pending; bit1 = state==APPLY; bits[31:16] = commit count; other bits 0. Writes are ignored.
- Write qualifier: chipselect && !write_n. Reads have no side effects. Reads of 0–5 return the shadow value, not the active value.
- FSM states:
  - IDLE:
    - CTRL bit1 → APPLY.
    - Otherwise CTRL bit0 → PENDING.
    - A frame_sync in IDLE is ignored, including when it coincides with the commit write; that commit waits for the next frame_sync.
  - PENDING:
    - frame_sync or CTRL bit1 → APPLY.
    - A CTRL bit0 write is absorbed with no change.
  - APPLY (exactly one cycle):
    - On the leaving edge: active <= shadow (all six words), params_updated <= 1, count <= count+1.
    - Next state is PENDING if a CTRL commit write (bit0 or bit1) occurs during APPLY, otherwise IDLE.
- Latency: frame_sync sampled at edge k in PENDING gives the state APPLY after k. Active outputs change and params_updated is high during the cycle after edge k+1.
- Shadow writes in PENDING are allowed; the last value written before the APPLY edge is committed.
- A shadow write on the APPLY edge lands in shadow only. The copy uses the pre-edge shadow, and the new value waits for a later commit.
- Commit counter wraps from 2^CNT_W−1 to 0.
- commit_pending = (state==PENDING), registered by construction.
- Reset mid-operation: on reset_n low, everything returns immediately to reset values and any pending commit is discarded.

Decomposition:
- Shared package (camera_pkg):
  - state enum {IDLE, PENDING, APPLY}.
  - Address constants ADDR_EYE_X..ADDR_LOOKAT_Z, ADDR_CTRL, ADDR_STATUS.
  - CTRL bit indices CTRL_COMMIT=0, CTRL_FORCE=1.
- One natural sub-module, camera_shadow_regfile: the six shadow words with the Avalon write decode and read mux. The FSM, active registers and counter stay in the top.

Test Plan:
- Reset, then read addresses 0–7 → all return 0; all outputs 0; commit_pending 0.
- Write eye_x=0x00010000 and lookat_z=0xFFFF0000, then CTRL=1 → commit_pending=1, eye_x output still 0. Pulse frame_sync → two cycles later eye_x=0x00010000 and lookat_z=0xFFFF0000, params_updated high for exactly one cycle, STATUS=0x00010000.
- CTRL=1 written in the same cycle as frame_sync from IDLE → no update. Next frame_sync → update; count=1.
- CTRL=2 (force) with no frame_sync → active outputs update on the following edge; count increments.
- In PENDING, write eye_y=5 then eye_y=7, then frame_sync → eye_y=7. Write eye_y=9 on the APPLY edge → eye_y output stays 7, shadow reads 9.
- Assert reset_n low while PENDING → commit_pending=0 immediately. A later frame_sync causes no update.
